// File: rtl/bottle_changer.sv
// Conveyor responder to the controller's bottle-change request: runs the motor until the
// full bottle has left and an empty one has arrived, counts changes and flags conveyor stalls.
module bottle_changer #(
  parameter int DEBOUNCE = 16,
  parameter int MOVE_MIN = 8,
  parameter int TIMEOUT  = 1000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       enable,
  input  logic       change_req,
  input  logic       bottle_sensor,
  output logic       motor,
  output logic       busy,
  output logic       change_done,
  output logic       timeout_err,
  output logic [9:0] bottle_count,
  output logic [2:0] state_dbg
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int MW = $clog2(MOVE_MIN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [MW-1:0] M_MAX  = MW'(MOVE_MIN);
  localparam logic [MW-1:0] M_ONE  = MW'(1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEAVE  = 3'd1,
    S_ARRIVE = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            s1_q, s2_q;
  logic            stable_q, stable_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            req_d_q;
  logic [MW-1:0]   mcnt_q, mcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d, tcnt_inc;
  logic            motor_q, motor_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            terr_q, terr_d;
  logic [9:0]      count_q, count_d;
  logic            req_rise;

  assign req_rise = change_req & ~req_d_q;

  // Debouncer: stable flips only after DEBOUNCE consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = '0;
    if (s2_q != stable_q) begin
      if (dcnt_q == D_LAST) begin
        stable_d = ~stable_q;
      end else begin
        dcnt_d = dcnt_q + D_ONE;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mcnt_d   = mcnt_q;
    tcnt_d   = tcnt_q;
    tcnt_inc = tcnt_q + T_ONE;
    case (state_q)
      S_IDLE: begin
        if (req_rise) begin
          state_d = S_LEAVE;
          mcnt_d  = '0;
          tcnt_d  = '0;
        end
      end
      S_LEAVE: begin
        if (mcnt_q != M_MAX) mcnt_d = mcnt_q + M_ONE;
        tcnt_d = tcnt_inc;
        // The stall check has priority over a simultaneous exit.
        if (tcnt_inc == T_MAX)                     state_d = S_FAULT;
        else if ((mcnt_q == M_MAX) && !stable_q)   state_d = S_ARRIVE;
      end
      S_ARRIVE: begin
        tcnt_d = tcnt_inc;
        if (tcnt_inc == T_MAX) state_d = S_FAULT;
        else if (stable_q)     state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (!enable) begin
      state_d = S_IDLE;
      mcnt_d  = '0;
      tcnt_d  = '0;
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    motor_d = (state_d == S_LEAVE) || (state_d == S_ARRIVE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    terr_d  = (state_d == S_FAULT);
    count_d = done_d ? (count_q + 10'd1) : count_q;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      dcnt_q   <= '0;
      req_d_q  <= 1'b0;
      state_q  <= S_IDLE;
      mcnt_q   <= '0;
      tcnt_q   <= '0;
      motor_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      s1_q     <= bottle_sensor;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      req_d_q  <= change_req;
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      tcnt_q   <= tcnt_d;
      motor_q  <= motor_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
      count_q  <= count_d;
    end
  end

  assign motor        = motor_q;
  assign busy         = busy_q;
  assign change_done  = done_q;
  assign timeout_err  = terr_q;
  assign bottle_count = count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_bottle_changer.sv
// Bench for bottle_changer: table of change scenarios timed against the request edge,
// plus hand sequences for reset, abort and count wrap.
module tb_bottle_changer;

  localparam int DEBOUNCE = 4;
  localparam int MOVE_MIN = 3;
  localparam int TIMEOUT  = 50;

  logic       clock = 1'b0;
  logic       rst, enable, change_req, bottle_sensor;
  logic       motor, busy, change_done, timeout_err;
  logic [9:0] bottle_count;
  logic [2:0] state_dbg;

  bottle_changer #(.DEBOUNCE(DEBOUNCE), .MOVE_MIN(MOVE_MIN), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .rst(rst), .enable(enable), .change_req(change_req),
    .bottle_sensor(bottle_sensor), .motor(motor), .busy(busy),
    .change_done(change_done), .timeout_err(timeout_err),
    .bottle_count(bottle_count), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int failures = 0;
  int cnt_exp = 0;
  logic [8:0] exp_q[$];   // {fault, event edge} per scenario

  // Event edges are counted from edge 0, the edge after which change_req is raised;
  // 99 marks an unused event.
  typedef struct {
    int init_s; int d0; int d1; int g_on; int g_off; int rq_off; int rq_on;
    int exp_edge; bit exp_fault;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_row(input int idx, input vec_t v);
    int motor_bad = 0, busy_bad = 0, done_cnt = 0;
    bit got = 0;
    logic [8:0] exp_ev;
    @(posedge clock); #1;
    change_req = 1'b0; enable = 1'b1; bottle_sensor = v.init_s[0];
    repeat (12) @(posedge clock);
    exp_q.push_back({v.exp_fault, 8'(v.exp_edge)});
    for (int e = -1; e <= 60; e++) begin
      @(posedge clock); #1;
      if (e == 0)       change_req = 1'b1;
      if (e == v.rq_off) change_req = 1'b0;
      if (e == v.rq_on)  change_req = 1'b1;
      if (e == v.d0)    bottle_sensor = 1'b0;
      if (e == v.g_on)  bottle_sensor = 1'b1;
      if (e == v.g_off) bottle_sensor = 1'b0;
      if (e == v.d1)    bottle_sensor = 1'b1;
      @(negedge clock);
      if (motor !== ((e >= 1) && (e < v.exp_edge))) motor_bad++;
      if (busy !== (v.exp_fault ? (e >= 1) : ((e >= 1) && (e <= v.exp_edge)))) busy_bad++;
      if (change_done === 1'b1) done_cnt++;
      if (!got && (change_done === 1'b1 || timeout_err === 1'b1)) begin
        got = 1;
        exp_ev = exp_q.pop_front();
        check($sformatf("row%0d_event", idx), {timeout_err, 8'(e)}, exp_ev);
      end
    end
    if (!got) begin
      exp_ev = exp_q.pop_front();
      checks++; failures++;
      $display("FAIL row%0d_event actual=none expected=%0d", idx, exp_ev);
    end
    check($sformatf("row%0d_motor_profile_errs", idx), motor_bad, 0);
    check($sformatf("row%0d_busy_profile_errs", idx), busy_bad, 0);
    check($sformatf("row%0d_done_pulses", idx), done_cnt, v.exp_fault ? 0 : 1);
    if (v.exp_fault) begin
      check($sformatf("row%0d_fault_hold", idx), {motor, timeout_err}, 2'b01);
      @(posedge clock); #1;
      enable = 1'b0; change_req = 1'b0;
      @(posedge clock); #1;
      enable = 1'b1;
      @(negedge clock);
      check($sformatf("row%0d_clear_after_disable", idx),
            {busy, timeout_err, motor, state_dbg}, 6'd0);
      check($sformatf("row%0d_count_held", idx), bottle_count, cnt_exp);
    end else begin
      cnt_exp = (cnt_exp + 1) % 1024;
      @(posedge clock); #1;
      change_req = 1'b0;
      @(negedge clock);
      check($sformatf("row%0d_count", idx), bottle_count, cnt_exp);
    end
  endtask

  task automatic fast_change(output bit ok);
    ok = 0;
    @(posedge clock); #1;
    change_req = 1'b1; bottle_sensor = 1'b0;
    repeat (4) @(posedge clock); #1;
    bottle_sensor = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (change_done === 1'b1) ok = 1;
    end
    @(posedge clock); #1;
    change_req = 1'b0;
  endtask

  initial begin
    int bad;
    bit ok;
    vecs[0] = '{1,  5, 15, 99, 99, 99, 99, 22, 1'b0};  // nominal change
    vecs[1] = '{1,  0,  4, 99, 99, 99, 99, 11, 1'b0};  // early sensor edges
    vecs[2] = '{1,  0, 15,  8, 11, 99, 99, 22, 1'b0};  // 3-cycle glitch in ARRIVE
    vecs[3] = '{0, 99, -1, 99, 99, 99, 99,  6, 1'b0};  // no bottle at start: minimum latency
    vecs[4] = '{1,  5, 15, 99, 99,  2,  3, 22, 1'b0};  // second rise during LEAVE ignored
    vecs[5] = '{1,  0, 43, 99, 99, 99, 99, 50, 1'b0};  // done one edge before timeout
    vecs[6] = '{1,  0, 44, 99, 99, 99, 99, 51, 1'b1};  // done collides with timeout
    vecs[7] = '{1, 99, 99, 99, 99, 99, 99, 51, 1'b1};  // sensor stuck high

    rst = 1'b0; enable = 1'b0; change_req = 1'b0; bottle_sensor = 1'b1;
    #1;
    check("reset_outputs", {motor, busy, change_done, timeout_err}, 4'd0);
    check("reset_count", bottle_count, 0);
    check("reset_state", state_dbg, 0);
    repeat (2) @(posedge clock); #1;
    rst = 1'b1; enable = 1'b1;

    run_row(0, vecs[0]);
    run_row(1, vecs[1]);

    // Asynchronous reset in the middle of a change.
    @(posedge clock); #1;
    change_req = 1'b1;
    repeat (3) @(posedge clock); #2;
    check("pre_reset_motor", motor, 1);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {motor, busy, change_done, timeout_err}, 4'd0);
    check("async_reset_count", bottle_count, 0);
    cnt_exp = 0;
    change_req = 1'b0;
    @(posedge clock); #1;
    rst = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if ({motor, busy, change_done, timeout_err, state_dbg} !== 7'd0) bad++;
    end
    check("idle_after_reset_errs", bad, 0);

    for (int i = 2; i < 8; i++) run_row(i, vecs[i]);

    // Disable mid-LEAVE aborts; the still-high request must not restart.
    @(posedge clock); #1;
    change_req = 1'b1;
    repeat (2) @(posedge clock); #1;
    enable = 1'b0;
    @(posedge clock); #1;
    enable = 1'b1;
    @(negedge clock);
    check("abort_outputs", {motor, busy, state_dbg}, 5'd0);
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (motor !== 1'b0) bad++;
    end
    check("abort_no_retrigger_errs", bad, 0);
    check("abort_count_held", bottle_count, cnt_exp);
    @(posedge clock); #1;
    change_req = 1'b0;

    // Drive the counter to 1023, then wrap.
    bad = 0;
    while (cnt_exp < 1023) begin
      fast_change(ok);
      if (!ok) bad++;
      cnt_exp++;
    end
    check("wrap_missing_done", bad, 0);
    @(negedge clock);
    check("count_1023", bottle_count, 1023);
    fast_change(ok);
    cnt_exp = 0;
    check("wrap_done_seen", ok, 1);
    @(negedge clock);
    check("count_wrap", bottle_count, cnt_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
